// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the multi-cycle ALU: aluc opcode values and the
//   mul/div engine state encoding.
//   For single-cycle ops aluc[3] is don't-care except for the shift group
//   (SLL/SRL/SRA), so the decoder compares only the low bits of these
//   constants where the encoding allows it.
package alu_pkg;

  localparam logic [4:0] ALUC_ADD   = 5'b00000;
  localparam logic [4:0] ALUC_SUB   = 5'b00100;
  localparam logic [4:0] ALUC_AND   = 5'b00001;
  localparam logic [4:0] ALUC_OR    = 5'b00101;
  localparam logic [4:0] ALUC_XOR   = 5'b00010;
  localparam logic [4:0] ALUC_LUI   = 5'b00110;
  localparam logic [4:0] ALUC_SLL   = 5'b00011;
  localparam logic [4:0] ALUC_SRL   = 5'b00111;
  localparam logic [4:0] ALUC_SRA   = 5'b01111;
  localparam logic [4:0] ALUC_MULT  = 5'b10000;
  localparam logic [4:0] ALUC_MULTU = 5'b10001;
  localparam logic [4:0] ALUC_DIV   = 5'b10010;
  localparam logic [4:0] ALUC_DIVU  = 5'b10011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_t;

endpackage

// File: rtl/mc_alu_muldiv.sv
// mc_alu_muldiv
//   Iterative multiply/divide engine. Signed operands are converted to
//   sign-magnitude on acceptance, WIDTH shift-add (mul) or restoring
//   shift-subtract (div) steps run in CALC, and signs are applied in FIX.
//
//   state | meaning
//   IDLE  | waiting for go; latches magnitudes, signs and op
//   CALC  | one mul/div step per cycle, leaves when cnt reaches 0
//   FIX   | applies signs, writes hi/lo, pulses ready
//
// Ports
//   clock, reset     rising-edge clock, async active-high reset
//   go               accept a new op (only honoured in IDLE)
//   is_div           1 = divide, 0 = multiply
//   is_signed        1 = signed operands
//   a, b             operands (a = dividend, b = divisor)
//   busy             op in progress
//   ready            one-cycle pulse, hi/lo hold the new result
//   hi, lo           result registers (product high/low, remainder/quotient)
module mc_alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_t          r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_m;      // multiplicand (mul) or divisor magnitude (div)
  logic [WIDTH-1:0]   r_wh;     // partial product high / running remainder
  logic [WIDTH-1:0]   r_wl;     // multiplier bits / quotient bits
  logic               r_div;
  logic               r_dz;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_busy;
  logic               r_ready;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_rsh;
  logic               w_fits;
  logic [WIDTH-1:0]   w_trial;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;

  assign w_abs_a = (is_signed && a[WIDTH-1]) ? -a : a;
  assign w_abs_b = (is_signed && b[WIDTH-1]) ? -b : b;

  // Shift-add: add the multiplicand when the current multiplier bit is set,
  // then shift the {carry, acc, multiplier} pair right by one.
  assign w_add = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});

  // Restoring divide: remainder < divisor, so the shifted remainder is below
  // 2*divisor and a fitting trial difference always fits in WIDTH bits.
  assign w_rsh   = {r_wh, r_wl[WIDTH-1]};
  assign w_fits  = (w_rsh >= {1'b0, r_m});
  assign w_trial = w_rsh[WIDTH-1:0] - r_m;

  assign w_prod   = {r_wh, r_wl};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;
  assign w_q      = r_neg_q ? -r_wl : r_wl;
  assign w_r      = r_neg_r ? -r_wh : r_wh;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_m     <= '0;
      r_wh    <= '0;
      r_wl    <= '0;
      r_div   <= 1'b0;
      r_dz    <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (go) begin
            r_busy  <= 1'b1;
            r_cnt   <= CNT_W'(WIDTH-1);
            r_div   <= is_div;
            r_neg_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_r <= is_signed & is_div & a[WIDTH-1];
            if (is_div && (b == '0)) begin
              // Divide by zero bypasses CALC; raw a goes to hi unchanged.
              r_dz    <= 1'b1;
              r_wh    <= a;
              r_wl    <= '1;
              r_state <= FIX;
            end else begin
              r_dz    <= 1'b0;
              r_wh    <= '0;
              r_m     <= is_div ? w_abs_b : w_abs_a;
              r_wl    <= is_div ? w_abs_a : w_abs_b;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          if (r_div) begin
            r_wh <= w_fits ? w_trial : w_rsh[WIDTH-1:0];
            r_wl <= {r_wl[WIDTH-2:0], w_fits};
          end else begin
            r_wh <= w_add[WIDTH:1];
            r_wl <= {w_add[0], r_wl[WIDTH-1:1]};
          end
          if (r_cnt == '0) begin
            r_state <= FIX;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        FIX: begin
          if (r_dz) begin
            r_hi <= r_wh;
            r_lo <= r_wl;
          end else if (r_div) begin
            r_hi <= w_r;
            r_lo <= w_q;
          end else begin
            r_hi <= w_prod_s[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_s[WIDTH-1:0];
          end
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy  = r_busy;
  assign ready = r_ready;
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

// File: rtl/mc_alu.sv
// mc_alu
//   Multi-cycle ALU for the EX stage. Single-cycle ops load s/z one edge
//   after start; MULT/MULTU/DIV/DIVU run in mc_alu_muldiv and land in hi/lo.
//   Optional feature: define MC_ALU_OVF_EN to add the ovf output (signed
//   overflow of ADD/SUB, registered with s).
//
// Ports
//   clock, reset   rising-edge clock, async active-high reset
//   start          op request, sampled only while busy=0
//   aluc           op code
//   a, b           operands (a supplies the shift amount for shifts)
//   s, z           registered single-cycle result and its zero flag
//   hi, lo         mul/div result registers
//   busy           mul/div in progress
//   done           one-cycle pulse when a result is valid
//   ovf            (MC_ALU_OVF_EN only) signed overflow of ADD/SUB
module mc_alu
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       aluc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             z,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
`ifdef MC_ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH-1:0]   r_s;
  logic               r_z;
  logic               r_done;

  logic               w_is_md;
  logic               w_accept;
  logic               w_go;
  logic               w_sc;
  logic               w_md_busy;
  logic               w_md_ready;
  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH-1:0]   w_res;

  // Only 10000..10011 are mul/div; other aluc[4]=1 codes act as single-cycle s=0.
  assign w_is_md  = aluc[4] & (aluc[3:2] == ALUC_MULT[3:2]);
  assign w_accept = start & ~w_md_busy;
  assign w_go     = w_accept & w_is_md;
  assign w_sc     = w_accept & ~w_is_md;

  assign w_sum   = a + b;
  assign w_diff  = a - b;
  assign w_shamt = a[SHAMT_W-1:0];

  always_comb begin
    w_res = '0;
    if (!aluc[4]) begin
      case (aluc[2:0])
        ALUC_ADD[2:0]: w_res = w_sum;
        ALUC_SUB[2:0]: w_res = w_diff;
        ALUC_AND[2:0]: w_res = a & b;
        ALUC_OR[2:0]:  w_res = a | b;
        ALUC_XOR[2:0]: w_res = a ^ b;
        ALUC_LUI[2:0]: w_res = b << (WIDTH/2);
        ALUC_SLL[2:0]: w_res = (aluc[3] == ALUC_SLL[3]) ? (b << w_shamt) : '0;
        ALUC_SRL[2:0]: w_res = (aluc[3] == ALUC_SRA[3]) ? $unsigned($signed(b) >>> w_shamt)
                                                        : (b >> w_shamt);
        default:       w_res = '0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s    <= '0;
      r_z    <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_sc;
      if (w_sc) begin
        r_s <= w_res;
        r_z <= (w_res == '0);
      end
    end
  end

`ifdef MC_ALU_OVF_EN
  logic r_ovf;
  logic w_ovf;

  always_comb begin
    w_ovf = 1'b0;
    if (aluc[4] == 1'b0 && aluc[2:0] == ALUC_ADD[2:0])
      w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
    else if (aluc[4] == 1'b0 && aluc[2:0] == ALUC_SUB[2:0])
      w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_sc) begin
      r_ovf <= w_ovf;
    end
  end

  assign ovf = r_ovf;
`endif

  mc_alu_muldiv #(
    .WIDTH (WIDTH),
    .CNT_W (SHAMT_W)
  ) u_muldiv (
    .clock     (clock),
    .reset     (reset),
    .go        (w_go),
    .is_div    (aluc[1]),
    .is_signed (~aluc[0]),
    .a         (a),
    .b         (b),
    .busy      (w_md_busy),
    .ready     (w_md_ready),
    .hi        (hi),
    .lo        (lo)
  );

  // Single-cycle and mul/div completions never overlap: a single-cycle op
  // can only be accepted once the engine has returned to IDLE.
  assign s    = r_s;
  assign z    = r_z;
  assign busy = w_md_busy;
  assign done = r_done | w_md_ready;

endmodule
